rr_unpacker: RTL and testbench

Stream unpacker that accepts multi-word records of up to NWORDS words on a wide valid/ready input and emits them one word per beat on a narrow valid/ready output, marking the final word of each record. It is the read-out end of the record-log path. It sits between a record buffer that stores packed entries and the narrow replay/consumer stream. Output channel is fully registered; it sustains one word per cycle, including back-to-back records with no bubble.

---
 rtl/rr_unpacker.sv | 107 ++++++++++
 tb/tb_rr_unpacker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_unpacker.sv
// Record unpacker: accepts up to NWORDS packed words per record and replays them one word
// per beat on a registered valid/ready stream, flagging the final word of each record.
module rr_unpacker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NWORDS     = 4,
  parameter int unsigned LEN_WIDTH  = $clog2(NWORDS + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic [NWORDS*DATA_WIDTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]         in_len,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         err_len
);

  // Keep at least one hold slot so NWORDS == 1 still elaborates.
  localparam int unsigned HoldWords = (NWORDS > 1) ? NWORDS - 1 : 1;
  localparam logic [LEN_WIDTH:0] NwordsWide = (LEN_WIDTH + 1)'(NWORDS);

  logic [HoldWords-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0]                data_q, data_d;
  logic [LEN_WIDTH-1:0]                 rem_q, rem_d;
  logic                                 valid_q, valid_d;
  logic                                 last_q, last_d;
  logic                                 err_q, err_d;

  logic                 insert, remove, drain, len_over;
  logic [LEN_WIDTH-1:0] len_eff;

  assign remove   = valid_q && out_ready;
  assign drain    = remove && last_q;
  assign in_ready = rstn && (!valid_q || drain);
  assign insert   = in_valid && in_ready;
  assign len_over = {1'b0, in_len} > NwordsWide;
  assign len_eff  = len_over ? NwordsWide[LEN_WIDTH-1:0] : in_len;

  always_comb begin
    hold_d  = hold_q;
    data_d  = data_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;

    if (remove && !last_q) begin
      data_d = hold_q[0];
      for (int i = 0; i < int'(HoldWords) - 1; i++) begin
        hold_d[i] = hold_q[i+1];
      end
      hold_d[HoldWords-1] = '0;
      rem_d  = rem_q - 1'b1;
      last_d = (rem_q == LEN_WIDTH'(1));
    end

    if (drain) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    // A new record overrides the drain result so back-to-back records leave no bubble.
    if (insert) begin
      err_d = len_over;
      if (len_eff != '0) begin
        data_d = in_data[DATA_WIDTH-1:0];
        for (int i = 0; i < int'(HoldWords); i++) begin
          if (i + 1 < int'(NWORDS)) begin
            hold_d[i] = in_data[(i+1)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            hold_d[i] = '0;
          end
        end
        rem_d   = len_eff - 1'b1;
        last_d  = (len_eff == LEN_WIDTH'(1));
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_rr_unpacker.sv
// Directed bench for rr_unpacker: hand-computed per-cycle expectations on every output.
module tb_rr_unpacker;

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned LW = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic [NW*DW-1:0] in_data;
  logic [LW-1:0]    in_len;
  logic             in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             out_ready;
  logic             err_len;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_unpacker #(.DATA_WIDTH(DW), .NWORDS(NW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err_len   (err_len)
  );

  // Upstream obligation: a stalled record must not change while in_valid stays high.
  logic             p_stall;
  logic [NW*DW-1:0] p_data;
  logic [LW-1:0]    p_len;
  always @(posedge clk) begin
    if (p_stall && in_valid) begin
      assert (in_data == p_data && in_len == p_len)
        else $error("stalled record changed while in_valid held");
    end
    p_stall <= rstn && in_valid && !in_ready;
    p_data  <= in_data;
    p_len   <= in_len;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                            input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"}, out_data, d);
    check({tag, "_last"}, 32'(out_last), 32'(l));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [NW*DW-1:0] pack(input logic [31:0] w0, input logic [31:0] w1,
                                            input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  localparam logic [31:0] WA = 32'hA000_000A, WB = 32'hB000_000B, WC = 32'hC000_000C;
  localparam logic [31:0] WD = 32'hD000_000D, WE = 32'hE000_000E, WF = 32'hF000_000F;
  localparam logic [31:0] WG = 32'h1234_5678, WH = 32'h0000_1111, WI = 32'h0000_2222;
  localparam logic [31:0] WJ = 32'h3333_0001, WK = 32'h3333_0002, WL = 32'h3333_0003;
  localparam logic [31:0] WM = 32'h3333_0004, WN = 32'h4444_0001, WO = 32'h4444_0002;
  localparam logic [31:0] WP = 32'h4444_0003, WQ = 32'h4444_0004;

  initial begin
    p_stall   = 1'b0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    out_ready = 1'b1;

    // Reset state
    cyc(); cyc(); settle();
    expect_out("rst", 1'b0, 32'h0, 1'b0);
    check("rst_err", 32'(err_len), 32'h0);
    check("rst_rdy", 32'(in_ready), 32'h0);

    // Single record L=3
    cyc(); rstn = 1'b1; in_valid = 1'b1; in_data = pack(WA, WB, WC, 32'h0); in_len = 3'd3;
    settle(); check("t1_rdy0", 32'(in_ready), 32'h1);
    cyc(); in_valid = 1'b0; settle();
    expect_out("t1_w0", 1'b1, WA, 1'b0); check("t1_rdy1", 32'(in_ready), 32'h0);
    cyc(); settle(); expect_out("t1_w1", 1'b1, WB, 1'b0);
    cyc(); settle(); expect_out("t1_w2", 1'b1, WC, 1'b1);
    check("t1_rdy3", 32'(in_ready), 32'h1);
    cyc(); settle(); expect_out("t1_idle", 1'b0, WC, 1'b0);

    // Back-to-back L=2 then L=1
    in_valid = 1'b1; in_data = pack(WA, WB, 32'h0, 32'h0); in_len = 3'd2;
    settle();
    cyc(); in_data = pack(WC, 32'h0, 32'h0, 32'h0); in_len = 3'd1; settle();
    expect_out("t2_w0", 1'b1, WA, 1'b0); check("t2_rdy1", 32'(in_ready), 32'h0);
    cyc(); settle();
    expect_out("t2_w1", 1'b1, WB, 1'b1); check("t2_rdy2", 32'(in_ready), 32'h1);
    cyc(); in_valid = 1'b0; settle();
    expect_out("t2_w2", 1'b1, WC, 1'b1);
    cyc(); settle(); check("t2_idle", 32'(out_valid), 32'h0);

    // Backpressure L=4, out_ready low for three cycles
    in_valid = 1'b1; in_data = pack(WD, WE, WF, WG); in_len = 3'd4; settle();
    cyc(); in_valid = 1'b0; settle();
    expect_out("t3_w0", 1'b1, WD, 1'b0); check("t3_rdy1", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(); out_ready = 1'b0; settle();
      expect_out("t3_stall", 1'b1, WE, 1'b0); check("t3_rdy_st", 32'(in_ready), 32'h0);
    end
    cyc(); out_ready = 1'b1; settle(); expect_out("t3_w1", 1'b1, WE, 1'b0);
    cyc(); settle(); expect_out("t3_w2", 1'b1, WF, 1'b0);
    check("t3_rdy6", 32'(in_ready), 32'h0);
    cyc(); settle(); expect_out("t3_w3", 1'b1, WG, 1'b1);
    check("t3_rdy7", 32'(in_ready), 32'h1);
    cyc(); settle(); check("t3_idle", 32'(out_valid), 32'h0);

    // Zero-length record between two L=1 records
    in_valid = 1'b1; in_data = pack(WH, 32'h0, 32'h0, 32'h0); in_len = 3'd1; settle();
    cyc(); in_data = pack(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0); in_len = 3'd0; settle();
    expect_out("t4_w0", 1'b1, WH, 1'b1); check("t4_rdy1", 32'(in_ready), 32'h1);
    cyc(); in_data = pack(WI, 32'h0, 32'h0, 32'h0); in_len = 3'd1; settle();
    check("t4_gap_valid", 32'(out_valid), 32'h0); check("t4_gap_err", 32'(err_len), 32'h0);
    check("t4_rdy2", 32'(in_ready), 32'h1);
    cyc(); in_valid = 1'b0; settle(); expect_out("t4_w1", 1'b1, WI, 1'b1);
    cyc(); settle(); check("t4_idle", 32'(out_valid), 32'h0);

    // Over-length record clamps to NWORDS and flags err_len once
    in_valid = 1'b1; in_data = pack(WJ, WK, WL, WM); in_len = 3'd5; settle();
    cyc(); in_valid = 1'b0; settle();
    expect_out("t5_w0", 1'b1, WJ, 1'b0); check("t5_err1", 32'(err_len), 32'h1);
    cyc(); settle(); expect_out("t5_w1", 1'b1, WK, 1'b0);
    check("t5_err2", 32'(err_len), 32'h0);
    cyc(); settle(); expect_out("t5_w2", 1'b1, WL, 1'b0);
    cyc(); settle(); expect_out("t5_w3", 1'b1, WM, 1'b1);
    check("t5_err4", 32'(err_len), 32'h0);
    cyc(); settle(); check("t5_idle", 32'(out_valid), 32'h0);

    // Reset mid-record discards pending words
    in_valid = 1'b1; in_data = pack(WN, WO, WP, WQ); in_len = 3'd4; settle();
    cyc(); in_valid = 1'b0; settle(); expect_out("t6_w0", 1'b1, WN, 1'b0);
    cyc(); rstn = 1'b0; settle();
    expect_out("t6_w1", 1'b1, WO, 1'b0); check("t6_rdy_rst", 32'(in_ready), 32'h0);
    cyc(); rstn = 1'b1; settle();
    expect_out("t6_post", 1'b0, 32'h0, 1'b0); check("t6_rdy", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle(); check("t6_quiet", 32'(out_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
